// File: rtl/gpio_irq_if.sv
// APB slave segment carrying the GPIO register interface.
// Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by an
// access cycle (psel=1, penable=1); pready is tied high, so every access
// completes in its first access cycle, writes commit on that clock edge and
// prdata/pslverr are valid combinationally during it.
interface gpio_irq_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/gpio_irq.sv
// Parametrised GPIO block: OUT/OEN registers with XOR/SET/CLR aliases,
// per-pin alternate-function select, input synchroniser, sticky W1C edge
// flags with rise/fall enables and a single registered interrupt line.
module gpio_irq #(
  parameter int                 N_GPIO      = 8,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [N_GPIO-1:0]  RESET_OEN   = '0,
  parameter logic [N_GPIO-1:0]  RESET_FSEL  = '0
) (
  input  logic              clk,
  input  logic              rst,
  gpio_irq_if.slave         apbs,
  input  logic [N_GPIO-1:0] alt_out,
  input  logic [N_GPIO-1:0] alt_oe,
  output logic [N_GPIO-1:0] padout_gpio,
  output logic [N_GPIO-1:0] padoe_gpio,
  input  logic [N_GPIO-1:0] padin_gpio,
  output logic              irq
);

  // Word index of the register map (offset >> 2)
  localparam logic [5:0] IDX_OUT       = 6'd0;
  localparam logic [5:0] IDX_OUT_XOR   = 6'd1;
  localparam logic [5:0] IDX_OUT_SET   = 6'd2;
  localparam logic [5:0] IDX_OUT_CLR   = 6'd3;
  localparam logic [5:0] IDX_OEN       = 6'd4;
  localparam logic [5:0] IDX_OEN_XOR   = 6'd5;
  localparam logic [5:0] IDX_OEN_SET   = 6'd6;
  localparam logic [5:0] IDX_OEN_CLR   = 6'd7;
  localparam logic [5:0] IDX_IN        = 6'd8;
  localparam logic [5:0] IDX_FSEL      = 6'd9;
  localparam logic [5:0] IDX_INTR_RISE = 6'd10;
  localparam logic [5:0] IDX_INTR_FALL = 6'd11;
  localparam logic [5:0] IDX_INTE_RISE = 6'd12;
  localparam logic [5:0] IDX_INTE_FALL = 6'd13;
  localparam logic [5:0] IDX_INTS      = 6'd14;

  logic [N_GPIO-1:0] r_out;
  logic [N_GPIO-1:0] r_oen;
  logic [N_GPIO-1:0] r_fsel;
  logic [N_GPIO-1:0] r_inte_rise;
  logic [N_GPIO-1:0] r_inte_fall;
  logic [N_GPIO-1:0] r_intr_rise;
  logic [N_GPIO-1:0] r_intr_fall;
  logic [N_GPIO-1:0] r_prev;
  logic [SYNC_STAGES-1:0][N_GPIO-1:0] r_sync;

  logic [5:0]        w_idx;
  logic              w_access;
  logic              w_wr;
  logic              w_unmapped;
  logic [N_GPIO-1:0] w_wd;
  logic [N_GPIO-1:0] w_sync_o;
  logic [N_GPIO-1:0] w_rise;
  logic [N_GPIO-1:0] w_fall;
  logic [N_GPIO-1:0] w_ints;
  logic [N_GPIO-1:0] w_clr_rise;
  logic [N_GPIO-1:0] w_clr_fall;
  logic [N_GPIO-1:0] w_rd;
  logic              w_unused_ok;

  assign w_idx      = apbs.paddr[7:2];
  assign w_access   = apbs.psel & apbs.penable;
  assign w_wr       = w_access & apbs.pwrite;
  assign w_unmapped = (w_idx > IDX_INTS);
  assign w_wd       = apbs.pwdata[N_GPIO-1:0];

  // Address bits outside the decode and data bits above the pin count are ignored
  assign w_unused_ok = ^{apbs.paddr[15:8], apbs.paddr[1:0], apbs.pwdata};

  assign w_sync_o = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_sync_o & ~r_prev;
  assign w_fall   = ~w_sync_o & r_prev;
  assign w_ints   = (r_intr_rise & r_inte_rise) | (r_intr_fall & r_inte_fall);

  assign w_clr_rise = (w_wr && w_idx == IDX_INTR_RISE) ? w_wd : '0;
  assign w_clr_fall = (w_wr && w_idx == IDX_INTR_FALL) ? w_wd : '0;

  assign padout_gpio = (r_fsel & alt_out) | (~r_fsel & r_out);
  assign padoe_gpio  = (r_fsel & alt_oe)  | (~r_fsel & r_oen);

  assign apbs.pready  = 1'b1;
  assign apbs.pslverr = w_access & w_unmapped;

  // Read mux: aliases return their base register, unmapped offsets read 0
  always_comb begin
    w_rd = '0;
    case (w_idx)
      IDX_OUT, IDX_OUT_XOR, IDX_OUT_SET, IDX_OUT_CLR: w_rd = r_out;
      IDX_OEN, IDX_OEN_XOR, IDX_OEN_SET, IDX_OEN_CLR: w_rd = r_oen;
      IDX_IN:        w_rd = w_sync_o;
      IDX_FSEL:      w_rd = r_fsel;
      IDX_INTR_RISE: w_rd = r_intr_rise;
      IDX_INTR_FALL: w_rd = r_intr_fall;
      IDX_INTE_RISE: w_rd = r_inte_rise;
      IDX_INTE_FALL: w_rd = r_inte_fall;
      IDX_INTS:      w_rd = w_ints;
      default:       w_rd = '0;
    endcase
  end

  assign apbs.prdata = apbs.psel ? 32'(w_rd) : 32'd0;

  // OUT register with write/XOR/SET/CLR aliases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else if (w_wr) begin
      case (w_idx)
        IDX_OUT:     r_out <= w_wd;
        IDX_OUT_XOR: r_out <= r_out ^ w_wd;
        IDX_OUT_SET: r_out <= r_out | w_wd;
        IDX_OUT_CLR: r_out <= r_out & ~w_wd;
        default:     r_out <= r_out;
      endcase
    end
  end

  // OEN register with write/XOR/SET/CLR aliases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_oen <= RESET_OEN;
    end else if (w_wr) begin
      case (w_idx)
        IDX_OEN:     r_oen <= w_wd;
        IDX_OEN_XOR: r_oen <= r_oen ^ w_wd;
        IDX_OEN_SET: r_oen <= r_oen | w_wd;
        IDX_OEN_CLR: r_oen <= r_oen & ~w_wd;
        default:     r_oen <= r_oen;
      endcase
    end
  end

  // Plain read/write configuration registers: function select and enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsel      <= RESET_FSEL;
      r_inte_rise <= '0;
      r_inte_fall <= '0;
    end else if (w_wr) begin
      if (w_idx == IDX_FSEL)      r_fsel      <= w_wd;
      if (w_idx == IDX_INTE_RISE) r_inte_rise <= w_wd;
      if (w_idx == IDX_INTE_FALL) r_inte_fall <= w_wd;
    end
  end

  // Input synchroniser chain and edge-history register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], padin_gpio};
      r_prev <= w_sync_o;
    end
  end

  // Sticky edge flags; a detected edge overrides a same-cycle W1C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_intr_rise <= '0;
      r_intr_fall <= '0;
    end else begin
      r_intr_rise <= (r_intr_rise & ~w_clr_rise) | w_rise;
      r_intr_fall <= (r_intr_fall & ~w_clr_fall) | w_fall;
    end
  end

  // Registered interrupt line from the masked flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= |w_ints;
  end

endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq: expected values go into a queue as each step
// is set up and are popped when the DUT output is sampled.
module tb_gpio_irq;
  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] alt_out;
  logic [N-1:0] alt_oe;
  logic [N-1:0] padout_gpio;
  logic [N-1:0] padoe_gpio;
  logic [N-1:0] padin_gpio;
  logic         irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  gpio_irq_if apbs_if ();

  gpio_irq #(.N_GPIO(N), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .apbs        (apbs_if),
    .alt_out     (alt_out),
    .alt_oe      (alt_oe),
    .padout_gpio (padout_gpio),
    .padoe_gpio  (padoe_gpio),
    .padin_gpio  (padin_gpio),
    .irq         (irq)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Scoreboard compare: pop the oldest expectation and check it
  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s no expectation queued, observed %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  // APB write: setup, access, commit on the following edge
  task automatic apb_write(input logic [15:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    apbs_if.psel = 1'b1; apbs_if.penable = 1'b0; apbs_if.pwrite = 1'b1;
    apbs_if.paddr = addr; apbs_if.pwdata = data;
    @(posedge clk); #1;
    apbs_if.penable = 1'b1;
    @(posedge clk); #1;
    apbs_if.psel = 1'b0; apbs_if.penable = 1'b0; apbs_if.pwrite = 1'b0;
  endtask

  // APB read: checks prdata and pslverr in the access phase
  task automatic apb_read(input logic [15:0] addr, input logic [31:0] exp, input string tag);
    logic [5:0] idx;
    idx = addr[7:2];
    expect_val(exp);
    expect_val({31'd0, (idx > 6'd14)});
    @(posedge clk); #1;
    apbs_if.psel = 1'b1; apbs_if.penable = 1'b0; apbs_if.pwrite = 1'b0;
    apbs_if.paddr = addr;
    @(posedge clk); #1;
    apbs_if.penable = 1'b1;
    #1;
    chk(tag, apbs_if.prdata);
    chk({tag, "_slverr"}, {31'd0, apbs_if.pslverr});
    @(posedge clk); #1;
    apbs_if.psel = 1'b0; apbs_if.penable = 1'b0;
  endtask

  task automatic chk_pads(input string tag, input logic [N-1:0] e_out, input logic [N-1:0] e_oe);
    expect_val({24'd0, e_out});
    expect_val({24'd0, e_oe});
    chk({tag, "_padout"}, {24'd0, padout_gpio});
    chk({tag, "_padoe"}, {24'd0, padoe_gpio});
  endtask

  task automatic chk_irq(input string tag, input logic e);
    expect_val({31'd0, e});
    chk(tag, {31'd0, irq});
  endtask

  initial begin
    rst = 1'b0;
    alt_out = '0; alt_oe = '0; padin_gpio = '0;
    apbs_if.psel = 1'b0; apbs_if.penable = 1'b0; apbs_if.pwrite = 1'b0;
    apbs_if.paddr = '0; apbs_if.pwdata = '0;

    // Reset values
    #3 rst = 1'b1;
    #20 rst = 1'b0;
    chk_irq("rst_irq", 1'b0);
    chk_pads("rst", 8'h00, 8'h00);
    apb_read(16'h00, 32'h0, "rst_out");
    apb_read(16'h10, 32'h0, "rst_oen");
    apb_read(16'h20, 32'h0, "rst_in");
    apb_read(16'h24, 32'h0, "rst_fsel");
    apb_read(16'h28, 32'h0, "rst_intr_rise");
    apb_read(16'h2C, 32'h0, "rst_intr_fall");
    apb_read(16'h30, 32'h0, "rst_inte_rise");
    apb_read(16'h38, 32'h0, "rst_ints");
    apb_read(16'h3C, 32'h0, "unmapped_3c");

    // OUT aliases
    apb_write(16'h00, 32'hA5); chk_pads("out_wr", 8'hA5, 8'h00);
    apb_read(16'h00, 32'hA5, "out_wr");
    apb_write(16'h04, 32'h0F); chk_pads("out_xor", 8'hAA, 8'h00);
    apb_read(16'h04, 32'hAA, "out_xor");
    apb_write(16'h08, 32'h10); chk_pads("out_set", 8'hBA, 8'h00);
    apb_read(16'h08, 32'hBA, "out_set");
    apb_write(16'h0C, 32'h80); chk_pads("out_clr", 8'h3A, 8'h00);
    apb_read(16'h0C, 32'h3A, "out_clr");
    apb_write(16'h3C, 32'hFF); apb_read(16'h00, 32'h3A, "unmapped_wr_ignored");

    // OEN aliases
    apb_write(16'h10, 32'hA5); chk_pads("oen_wr", 8'h3A, 8'hA5);
    apb_write(16'h14, 32'h0F); chk_pads("oen_xor", 8'h3A, 8'hAA);
    apb_write(16'h18, 32'h10); chk_pads("oen_set", 8'h3A, 8'hBA);
    apb_write(16'h1C, 32'h80); chk_pads("oen_clr", 8'h3A, 8'h3A);
    apb_read(16'h1C, 32'h3A, "oen_alias_rd");

    // Function select
    apb_write(16'h24, 32'hC0);
    alt_out = 8'hFF; alt_oe = 8'hC0;
    apb_write(16'h00, 32'h00);
    apb_write(16'h10, 32'h01);
    chk_pads("fsel", 8'hC0, 8'hC1);
    apb_read(16'h24, 32'hC0, "fsel_rd");

    // Rising edge on pin 0 with rise enabled: cycle-exact latency
    apb_write(16'h30, 32'h01);
    @(posedge clk); #1;
    apbs_if.psel = 1'b1; apbs_if.penable = 1'b1; apbs_if.pwrite = 1'b0;
    apbs_if.paddr = 16'h20;
    padin_gpio[0] = 1'b1;
    @(posedge clk); #1;
    expect_val(32'h0); chk("in_t1", apbs_if.prdata);
    @(posedge clk); #1;
    expect_val(32'h1); chk("in_t2", apbs_if.prdata);
    apbs_if.paddr = 16'h28; #1;
    expect_val(32'h0); chk("intr_rise_t2", apbs_if.prdata);
    chk_irq("irq_t2", 1'b0);
    @(posedge clk); #1;
    expect_val(32'h1); chk("intr_rise_t3", apbs_if.prdata);
    chk_irq("irq_t3", 1'b0);
    @(posedge clk); #1;
    chk_irq("irq_t4", 1'b1);
    apbs_if.psel = 1'b0; apbs_if.penable = 1'b0;

    // Falling edge: flag set, irq unaffected since fall is not enabled
    padin_gpio[0] = 1'b0;
    repeat (5) @(posedge clk);
    apb_read(16'h2C, 32'h01, "intr_fall");
    chk_irq("irq_fall_noen", 1'b1);
    apb_read(16'h38, 32'h01, "ints_rise_only");

    // Move enables to pin 3, clear pin 0 flag
    apb_write(16'h28, 32'h01);
    apb_write(16'h30, 32'h08);
    @(posedge clk); #1;
    chk_irq("irq_cleared", 1'b0);
    padin_gpio[3] = 1'b1;
    repeat (5) @(posedge clk);
    apb_read(16'h28, 32'h08, "rise3_set");
    chk_irq("irq_rise3", 1'b1);
    padin_gpio[3] = 1'b0;
    repeat (5) @(posedge clk);

    // W1C commit on the same edge as a detected rise: set wins
    @(posedge clk); #1;
    padin_gpio[3] = 1'b1;
    apb_write(16'h28, 32'h08);
    apb_read(16'h28, 32'h08, "w1c_collision");

    // W1C on a quiet cycle clears; irq drops one cycle later
    apb_write(16'h28, 32'h08);
    chk_irq("irq_after_w1c", 1'b1);
    @(posedge clk); #1;
    chk_irq("irq_fall_w1c", 1'b0);
    apb_read(16'h28, 32'h00, "w1c_quiet");

    // Async reset during a write to OUT with irq pending
    apb_write(16'h24, 32'h00);
    apb_write(16'h00, 32'h55);
    padin_gpio[5] = 1'b1;
    apb_write(16'h30, 32'h20);
    repeat (5) @(posedge clk);
    #1;
    chk_irq("irq_pre_rst", 1'b1);
    chk_pads("pre_rst", 8'h55, 8'h01);
    @(posedge clk); #1;
    apbs_if.psel = 1'b1; apbs_if.penable = 1'b0; apbs_if.pwrite = 1'b1;
    apbs_if.paddr = 16'h00; apbs_if.pwdata = 32'hFF;
    @(posedge clk); #1;
    apbs_if.penable = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_irq("irq_in_rst", 1'b0);
    chk_pads("in_rst", 8'h00, 8'h00);
    apbs_if.psel = 1'b0; apbs_if.penable = 1'b0; apbs_if.pwrite = 1'b0;
    @(posedge clk); #1;
    chk_irq("irq_in_rst2", 1'b0);
    rst = 1'b0;
    apbs_if.psel = 1'b1; apbs_if.penable = 1'b1; apbs_if.paddr = 16'h28;
    @(posedge clk); #1;
    expect_val(32'h0); chk("post_rst_t1", apbs_if.prdata);
    @(posedge clk); #1;
    expect_val(32'h0); chk("post_rst_t2", apbs_if.prdata);
    @(posedge clk); #1;
    expect_val(32'h28); chk("post_rst_t3", apbs_if.prdata);
    apbs_if.psel = 1'b0; apbs_if.penable = 1'b0;
    apb_read(16'h00, 32'h0, "post_rst_out");
    apb_read(16'h10, 32'h0, "post_rst_oen");
    apb_read(16'h30, 32'h0, "post_rst_inte");
    chk_irq("post_rst_irq", 1'b0);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations count %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
